// File: rtl/mips_defs.sv
// Shared definitions for the HI/LO multiply/divide sequencer.
// Holds the op encodings driven on md_sched.op, the sequencer state
// encoding and the default busy latencies.
package mips_defs;

    localparam logic [1:0] MD_MULT  = 2'b00;
    localparam logic [1:0] MD_MULTU = 2'b01;
    localparam logic [1:0] MD_DIV   = 2'b10;
    localparam logic [1:0] MD_DIVU  = 2'b11;

    typedef enum logic {
        MD_IDLE = 1'b0,
        MD_RUN  = 1'b1
    } md_state_t;

    localparam int MD_MULT_CYC_DEF = 5;
    localparam int MD_DIV_CYC_DEF  = 10;

endpackage

// File: rtl/md_arith.sv
// Combinational multiply/divide datapath.
// Ports:
//   op     in  2   operation (MD_MULT/MD_MULTU/MD_DIV/MD_DIVU)
//   a, b   in  32  operands (rs, rt)
//   res_hi out 32  product high word or remainder
//   res_lo out 32  product low word or quotient
//   dz     out 1   divide by zero
module md_arith
    import mips_defs::*;
(
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] res_hi,
    output logic [31:0] res_lo,
    output logic        dz
);

    logic signed [63:0] w_prod_s;
    logic        [63:0] w_prod_u;
    logic signed [31:0] w_sa;
    logic signed [31:0] w_sb;
    logic signed [31:0] w_quo_s;
    logic signed [31:0] w_rem_s;
    logic        [31:0] w_ub;
    logic               w_b_zero;
    logic               w_s_ovf;

    assign w_b_zero = (b == 32'd0);
    // Most-negative / -1 overflows a signed divide; its result is defined
    // explicitly so simulation and silicon agree.
    assign w_s_ovf  = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);

    assign w_prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    assign w_prod_u = {32'd0, a} * {32'd0, b};

    // A zero divisor is replaced by 1; the result is discarded via dz anyway.
    assign w_sa = $signed(a);
    assign w_sb = (w_b_zero || w_s_ovf) ? 32'sd1 : $signed(b);
    assign w_ub = w_b_zero ? 32'd1 : b;

    assign w_quo_s = w_sa / w_sb;
    assign w_rem_s = w_s_ovf ? 32'sd0 : (w_sa % w_sb);

    always_comb begin
        res_hi = 32'd0;
        res_lo = 32'd0;
        dz     = 1'b0;
        case (op)
            MD_MULT: begin
                res_hi = w_prod_s[63:32];
                res_lo = w_prod_s[31:0];
            end
            MD_MULTU: begin
                res_hi = w_prod_u[63:32];
                res_lo = w_prod_u[31:0];
            end
            MD_DIV: begin
                res_hi = w_rem_s;
                res_lo = w_quo_s;
                dz     = w_b_zero;
            end
            default: begin
                res_hi = a % w_ub;
                res_lo = a / w_ub;
                dz     = w_b_zero;
            end
        endcase
    end

endmodule

// File: rtl/md_sched.sv
// HI/LO multiply/divide sequencer. Accepts mult/div and mthi/mtlo from E,
// holds a fixed-latency busy countdown, stalls D while occupied and
// suppresses any E-stage issue cancelled by an exception flush.
// Ports:
//   clk, rst (async, active low)
//   start, op, wr_hi, wr_lo, a, b, flush   E-stage issue
//   md_use_d                               D-stage HI/LO user
//   stall  out  hold D / bubble E (combinational)
//   busy   out  operation in progress
//   hi, lo out  architectural HI/LO
//
// state   | meaning
// --------+------------------------------------------------------
// MD_IDLE | free; accepts issue or mthi/mtlo
// MD_RUN  | result latched in pend_*, counting down to commit
module md_sched
    import mips_defs::*;
#(
    parameter int MULT_CYC = MD_MULT_CYC_DEF,
    parameter int DIV_CYC  = MD_DIV_CYC_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic        wr_hi,
    input  logic        wr_lo,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        flush,
    input  logic        md_use_d,
    output logic        stall,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    md_state_t   r_state;
    logic [3:0]  r_cnt;
    logic [31:0] r_pend_hi;
    logic [31:0] r_pend_lo;
    logic        r_pend_dz;
    logic [31:0] r_hi;
    logic [31:0] r_lo;

    logic [31:0] w_res_hi;
    logic [31:0] w_res_lo;
    logic        w_dz;

    md_arith u_arith (
        .op     (op),
        .a      (a),
        .b      (b),
        .res_hi (w_res_hi),
        .res_lo (w_res_lo),
        .dz     (w_dz)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= MD_IDLE;
            r_cnt     <= 4'd0;
            r_pend_hi <= 32'd0;
            r_pend_lo <= 32'd0;
            r_pend_dz <= 1'b0;
            r_hi      <= 32'd0;
            r_lo      <= 32'd0;
        end else begin
            case (r_state)
                MD_IDLE: begin
                    if (start && !flush) begin
                        r_pend_hi <= w_res_hi;
                        r_pend_lo <= w_res_lo;
                        r_pend_dz <= w_dz;
                        r_cnt     <= op[1] ? 4'(DIV_CYC) : 4'(MULT_CYC);
                        r_state   <= MD_RUN;
                    end else if (!flush) begin
                        if (wr_hi) r_hi <= a;
                        if (wr_lo) r_lo <= a;
                    end
                end
                default: begin
                    // flush is deliberately ignored here: the issuing
                    // instruction already committed past E.
                    r_cnt <= r_cnt - 4'd1;
                    if (r_cnt == 4'd1) begin
                        r_state <= MD_IDLE;
                        if (!r_pend_dz) begin
                            r_hi <= r_pend_hi;
                            r_lo <= r_pend_lo;
                        end
                    end
                end
            endcase
        end
    end

    assign busy  = (r_state == MD_RUN);
    assign stall = md_use_d & (busy | start);
    assign hi    = r_hi;
    assign lo    = r_lo;

endmodule

// File: tb/tb_md_sched.sv
module tb_md_sched;

    localparam int NMULT = 5;
    localparam int NDIV  = 10;

    logic        clk;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic        wr_hi;
    logic        wr_lo;
    logic [31:0] a;
    logic [31:0] b;
    logic        flush;
    logic        md_use_d;
    logic        stall;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    int vectors;
    int miscompares;

    // reference architectural HI/LO
    logic [31:0] m_hi;
    logic [31:0] m_lo;

    md_sched #(.MULT_CYC(NMULT), .DIV_CYC(NDIV)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .op       (op),
        .wr_hi    (wr_hi),
        .wr_lo    (wr_lo),
        .a        (a),
        .b        (b),
        .flush    (flush),
        .md_use_d (md_use_d),
        .stall    (stall),
        .busy     (busy),
        .hi       (hi),
        .lo       (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // the bench must never produce decoder-illegal combinations
    always @(posedge clk) begin
        if (rst && start && (wr_hi || wr_lo)) begin
            miscompares++;
            $display("FAIL illegal_start_and_move: start=%b wr_hi=%b wr_lo=%b required exclusive", start, wr_hi, wr_lo);
        end
        if (rst && busy && (start || wr_hi || wr_lo) && !flush) begin
            miscompares++;
            $display("FAIL illegal_issue_in_run: start=%b wr=%b%b while busy", start, wr_hi, wr_lo);
        end
    end

    // Reference arithmetic from the operation definitions (sign/magnitude).
    task automatic model(input logic [1:0] o, input logic [31:0] va, input logic [31:0] vb,
                         output logic dz, output logic [31:0] rh, output logic [31:0] rl);
        longint      sa, sb, ma, mb, q, r, p;
        logic [63:0] up;
        sa = longint'($signed(va));
        sb = longint'($signed(vb));
        dz = 1'b0;
        rh = 32'd0;
        rl = 32'd0;
        case (o)
            2'b00: begin
                p  = sa * sb;
                up = p;
                rh = up[63:32];
                rl = up[31:0];
            end
            2'b01: begin
                up = {32'd0, va} * {32'd0, vb};
                rh = up[63:32];
                rl = up[31:0];
            end
            2'b10: begin
                if (vb == 32'd0) dz = 1'b1;
                else begin
                    ma = (sa < 0) ? -sa : sa;
                    mb = (sb < 0) ? -sb : sb;
                    q  = ma / mb;
                    if ((sa < 0) != (sb < 0)) q = -q;
                    r  = sa - q * sb;
                    up = q;
                    rl = up[31:0];
                    up = r;
                    rh = up[31:0];
                end
            end
            default: begin
                if (vb == 32'd0) dz = 1'b1;
                else begin
                    rl = va / vb;
                    rh = va % vb;
                end
            end
        endcase
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one issue for a cycle, then count busy cycles (bounded).
    task automatic issue(input logic [1:0] o, input logic [31:0] va, input logic [31:0] vb,
                         input logic fl, output int nbusy);
        start = 1'b1; op = o; a = va; b = vb; flush = fl;
        tick();
        start = 1'b0; flush = 1'b0; a = $urandom; b = $urandom;
        nbusy = 0;
        while (busy === 1'b1 && nbusy < 40) begin
            nbusy++;
            tick();
        end
    endtask

    task automatic move(input logic to_hi, input logic [31:0] v);
        wr_hi = to_hi; wr_lo = ~to_hi; a = v;
        tick();
        wr_hi = 1'b0; wr_lo = 1'b0;
        if (to_hi) m_hi = v; else m_lo = v;
    endtask

    task automatic test_reset();
        rst = 1'b0; md_use_d = 1'b1;
        #13;
        vectors++;
        if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0 || stall !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_outputs: busy=%b stall=%b hi=%h lo=%h required all 0", busy, stall, hi, lo);
        end
        rst = 1'b1; md_use_d = 1'b0;
        tick();
        vectors++;
        if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
            miscompares++;
            $display("FAIL after_reset: busy=%b hi=%h lo=%h required 0", busy, hi, lo);
        end
        m_hi = 32'd0; m_lo = 32'd0;
    endtask

    task automatic test_op(input string nm, input logic [1:0] o, input logic [31:0] va, input logic [31:0] vb,
                           input int ncyc);
        int nb;
        logic dz;
        logic [31:0] rh, rl;
        model(o, va, vb, dz, rh, rl);
        issue(o, va, vb, 1'b0, nb);
        if (!dz) begin m_hi = rh; m_lo = rl; end
        vectors++;
        if (nb !== ncyc) begin
            miscompares++;
            $display("FAIL %s_busy: got %0d busy cycles, required %0d", nm, nb, ncyc);
        end
        vectors++;
        if (hi !== m_hi || lo !== m_lo) begin
            miscompares++;
            $display("FAIL %s_result: hi=%h lo=%h required hi=%h lo=%h", nm, hi, lo, m_hi, m_lo);
        end
    endtask

    task automatic test_moves();
        move(1'b1, 32'h11);
        vectors++;
        if (hi !== 32'h11 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL mthi: hi=%h busy=%b required hi=00000011 busy=0", hi, busy);
        end
        move(1'b0, 32'h22);
        vectors++;
        if (lo !== 32'h22 || hi !== 32'h11 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL mtlo: hi=%h lo=%h busy=%b required 11/22 busy=0", hi, lo, busy);
        end
    endtask

    task automatic test_stall();
        int nst;
        logic dz;
        logic [31:0] rh, rl;
        model(2'b00, 32'd1234, 32'hFFFF_FF00, dz, rh, rl);
        md_use_d = 1'b1;
        start = 1'b1; op = 2'b00; a = 32'd1234; b = 32'hFFFF_FF00;
        #1;
        vectors++;
        if (stall !== 1'b1) begin
            miscompares++;
            $display("FAIL stall_issue_cycle: stall=%b required 1", stall);
        end
        tick();
        start = 1'b0;
        nst = 0;
        while (busy === 1'b1 && nst < 40) begin
            vectors++;
            if (stall !== 1'b1) begin
                miscompares++;
                $display("FAIL stall_busy_cycle: stall=%b required 1 at busy cycle %0d", stall, nst + 1);
            end
            nst++;
            tick();
        end
        m_hi = rh; m_lo = rl;
        vectors++;
        if (nst !== NMULT || stall !== 1'b0 || lo !== m_lo || hi !== m_hi) begin
            miscompares++;
            $display("FAIL stall_release: busy_cycles=%0d stall=%b lo=%h hi=%h required %0d 0 %h %h",
                     nst, stall, lo, hi, NMULT, m_lo, m_hi);
        end
        md_use_d = 1'b0;
    endtask

    task automatic test_flush_issue();
        int nb;
        md_use_d = 1'b1;
        start = 1'b1; flush = 1'b1; op = 2'b01; a = 32'd9; b = 32'd9;
        #1;
        vectors++;
        if (stall !== 1'b1) begin
            miscompares++;
            $display("FAIL flush_stall: stall=%b required 1", stall);
        end
        md_use_d = 1'b0;
        issue(2'b01, 32'd9, 32'd9, 1'b1, nb);
        vectors++;
        if (nb !== 0 || hi !== m_hi || lo !== m_lo) begin
            miscompares++;
            $display("FAIL flush_issue: busy_cycles=%0d hi=%h lo=%h required 0 %h %h", nb, hi, lo, m_hi, m_lo);
        end
    endtask

    task automatic test_flush_run();
        int nb;
        logic dz;
        logic [31:0] rh, rl;
        model(2'b11, 32'd1000, 32'd7, dz, rh, rl);
        start = 1'b1; op = 2'b11; a = 32'd1000; b = 32'd7;
        tick();
        start = 1'b0;
        nb = 0;
        while (busy === 1'b1 && nb < 40) begin
            flush = (nb == 2 || nb == 3);
            nb++;
            tick();
        end
        flush = 1'b0;
        m_hi = rh; m_lo = rl;
        vectors++;
        if (nb !== NDIV || hi !== m_hi || lo !== m_lo) begin
            miscompares++;
            $display("FAIL flush_in_run: busy_cycles=%0d hi=%h lo=%h required %0d %h %h", nb, hi, lo, NDIV, m_hi, m_lo);
        end
    endtask

    task automatic test_async_reset();
        start = 1'b1; op = 2'b10; a = 32'd100; b = 32'd3;
        tick();
        start = 1'b0;
        tick();
        tick();
        #2;
        rst = 1'b0;
        md_use_d = 1'b1;
        #1;
        vectors++;
        if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0 || stall !== 1'b0) begin
            miscompares++;
            $display("FAIL async_reset: busy=%b stall=%b hi=%h lo=%h required all 0", busy, stall, hi, lo);
        end
        md_use_d = 1'b0;
        m_hi = 32'd0; m_lo = 32'd0;
        @(negedge clk);
        rst = 1'b1;
        tick();
        vectors++;
        if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
            miscompares++;
            $display("FAIL reset_discard: busy=%b hi=%h lo=%h required 0", busy, hi, lo);
        end
        test_op("post_reset_mult", 2'b00, 32'h0001_0000, 32'h0003_0000, NMULT);
    endtask

    task automatic test_random();
        int nb;
        logic dz, fl;
        logic [1:0] o;
        logic [31:0] va, vb, rh, rl;
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                move($urandom_range(0, 1) == 1, $urandom);
                vectors++;
                if (hi !== m_hi || lo !== m_lo) begin
                    miscompares++;
                    $display("FAIL rand_move[%0d]: hi=%h lo=%h required %h %h", i, hi, lo, m_hi, m_lo);
                end
            end
            o  = 2'($urandom_range(0, 3));
            va = $urandom;
            case ($urandom_range(0, 3))
                0:       vb = 32'd0;
                1:       vb = 32'($urandom_range(1, 9));
                2:       vb = -32'($urandom_range(1, 9));
                default: vb = $urandom;
            endcase
            if (va == 32'h8000_0000 && vb == 32'hFFFF_FFFF) vb = 32'd3;
            fl = ($urandom_range(0, 7) == 0);
            model(o, va, vb, dz, rh, rl);
            issue(o, va, vb, fl, nb);
            if (!fl && !dz) begin m_hi = rh; m_lo = rl; end
            vectors++;
            if (nb !== (fl ? 0 : (o[1] ? NDIV : NMULT)) || hi !== m_hi || lo !== m_lo) begin
                miscompares++;
                $display("FAIL rand_op[%0d]: op=%0d a=%h b=%h flush=%b busy_cycles=%0d hi=%h lo=%h required hi=%h lo=%h",
                         i, o, va, vb, fl, nb, hi, lo, m_hi, m_lo);
            end
        end
    endtask

    initial begin
        vectors = 0; miscompares = 0;
        start = 1'b0; op = 2'b00; wr_hi = 1'b0; wr_lo = 1'b0;
        a = 32'd0; b = 32'd0; flush = 1'b0; md_use_d = 1'b0;
        m_hi = 32'd0; m_lo = 32'd0;

        test_reset();
        test_op("mult", 2'b00, 32'hFFFF_FFFE, 32'd3, NMULT);
        test_op("multu", 2'b01, 32'hFFFF_FFFE, 32'd3, NMULT);
        test_op("divu", 2'b11, 32'd7, 32'd2, NDIV);
        test_op("div_neg", 2'b10, 32'hFFFF_FFF9, 32'd2, NDIV);
        test_op("div_negdiv", 2'b10, 32'd7, 32'hFFFF_FFFE, NDIV);
        test_moves();
        test_op("div_zero", 2'b10, 32'd55, 32'd0, NDIV);
        test_op("back_to_back", 2'b00, 32'd6, 32'd7, NMULT);
        test_stall();
        test_flush_issue();
        test_flush_run();
        test_async_reset();
        test_random();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/md_sched.md
# md_sched

Sequencer and owner of the HI/LO multiply/divide resource in the five-stage pipeline. It accepts mult/multu/div/divu/mthi/mtlo issues from the E stage and runs a fixed-latency busy countdown. It raises a combinational stall toward the D stage while the unit is occupied, and honours the exception flush so that a cancelled E-stage instruction never touches HI/LO.

## Interface
Parameters:
- MULT_CYC, default 5, busy cycles for mult/multu (range 1..15)
- DIV_CYC, default 10, busy cycles for div/divu (range 1..15)

Ports:
- clk  in  1  pipeline clock, rising edge
- rst  in  1  asynchronous, active-low reset (asserted when 0)
- start  in  1  E stage holds a mult/multu/div/divu this cycle
- op  in  2  00 mult, 01 multu, 10 div, 11 divu; valid with start
- wr_hi  in  1  E stage holds mthi
- wr_lo  in  1  E stage holds mtlo
- a  in  32  rs operand from E
- b  in  32  rt operand from E
- flush  in  1  exception clear of D/E/M/W (DEMWclr); cancels this cycle's E-stage issue
- md_use_d  in  1  D-stage instruction is mult/div/mfhi/mflo/mthi/mtlo
- stall  out  1  hold D, bubble E
- busy  out  1  operation in progress
- hi  out  32  HI register
- lo  out  32  LO register

## Operation
- States: IDLE, RUN. Registers: state, cnt[3:0], pend_hi, pend_lo, pend_dz (div-by-zero flag), hi, lo.
- Reset (rst=0, any time, asynchronous): state=IDLE, cnt=0, busy=0, hi=0, lo=0, pend_*=0. Reset mid-RUN discards the pending result.
- Valid issue = start & ~flush & state==IDLE. Valid move = (wr_hi|wr_lo) & ~flush & state==IDLE.
- IDLE + valid issue: compute the result from a/b and op, latch it into pend_hi/pend_lo, and go to RUN.
  - cnt = MULT_CYC (op[1]=0) or DIV_CYC (op[1]=1).
  - mult: {pend_hi,pend_lo} = signed 64-bit product. multu: unsigned product.
  - div: pend_lo = signed quotient, pend_hi = signed remainder. The quotient truncates toward zero and the remainder takes the sign of the dividend.
  - divu: unsigned quotient and remainder.
  - b==0 on div/divu: pend_dz=1.
- RUN: cnt decrements every cycle. When cnt==1, go to IDLE and write hi/lo from pend, unless pend_dz, in which case hi/lo stay unchanged.
- Valid move writes hi (wr_hi) or lo (wr_lo) from a at that edge. It does not enter RUN.
- start and wr_hi/wr_lo in the same cycle is illegal (decoder guarantees exclusivity). The bench flags it.
- start or wr in RUN is ignored (stall prevents it). The bench flags it.
- flush does not abort an operation already in RUN: the committed instruction completes and writes HI/LO. flush only kills the same-cycle E issue.
- stall = md_use_d & (busy | start). This is combinational and independent of flush.
- busy = (state==RUN).

## Timing
- Issue sampled at edge t: busy=1 during cycles t+1 .. t+N (N = MULT_CYC or DIV_CYC).
- hi/lo take the new value at the edge ending cycle t+N and are visible from cycle t+N+1. busy is 0 in that same cycle.
- Back-to-back issue: a new start is legal in the first cycle busy=0.
- mthi/mtlo: hi/lo update at the sampling edge and are visible the next cycle. There is zero stall cost.
- mfhi/mflo in D during busy: stall held every busy cycle. It is released in cycle t+N+1 and reads the new value.
- All outputs are 0 during and immediately after reset.

## Structure
- Shared package (mips_defs): MD_MULT, MD_MULTU, MD_DIV, MD_DIVU op encodings; MD_IDLE and MD_RUN state encodings; default latency constants.
- One natural sub-module: md_arith. It is combinational and maps (op, a, b) to (res_hi, res_lo, dz). The arithmetic is isolated so it can later be replaced by a multicycle datapath.

## Test plan
- mult a=0xFFFFFFFE (-2), b=3 at edge 0 -> busy cycles 1-5, then hi=0xFFFFFFFF, lo=0xFFFFFFFA from cycle 6; busy=0 in cycle 6.
- divu a=7, b=2 -> busy 10 cycles, then hi=1, lo=3. div a=-7, b=2 -> hi=0xFFFFFFFF (-1), lo=0xFFFFFFFD (-3).
- div b=0 with hi=0x11, lo=0x22 preloaded by mthi/mtlo -> 10 busy cycles, then hi/lo still 0x11/0x22.
- md_use_d=1 with mflo in D during mult -> stall=1 for the issue cycle plus 5 busy cycles. It reads the product in cycle 6 with stall=0.
- start=1 with flush=1 -> no RUN, busy stays 0, hi/lo unchanged. Separately, flush during RUN leaves the result still committed on schedule.
- rst driven to 0 mid-RUN (cycle 3 of div), asynchronously between edges -> busy, hi and lo go to 0 immediately. After release, a new mult completes normally.
